// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation and FSM state encodings shared by the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result signals between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // rem < divisor <= 2^(WIDTH-1) always holds, so trial < 2^WIDTH and diff's MSB is a pure borrow.
  always_comb begin
    trial    = {rem, dbit};
    diff     = trial - {1'b0, divisor};
    qbit     = ~diff[WIDTH];
    rem_next = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed multiply/divide unit (radix-2 shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to compute MUL/MULH with a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int unsigned       CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state;
  op_e                op_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mag_d;
  logic [WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0] acc;

  op_e                op_in;
  logic               is_div_in;
  logic               a_neg;
  logic               b_neg;
  logic               special;
  logic               fast_hit;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   special_val;
  logic [WIDTH-1:0]   fast_val;

  logic [WIDTH-1:0]   d_rem;
  logic               d_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_val;

  always_comb begin
    op_in       = op_e'(bus.op);
    is_div_in   = (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg       = bus.src_a[WIDTH-1];
    b_neg       = bus.src_b[WIDTH-1];
    mag_a       = a_neg ? -bus.src_a : bus.src_a;
    mag_b       = b_neg ? -bus.src_b : bus.src_b;
    special     = 1'b0;
    special_val = '0;
    if (is_div_in) begin
      if (bus.src_b == '0) begin
        special     = 1'b1;
        special_val = (op_in == OP_DIV) ? '1 : bus.src_a;
      end else if (bus.src_a == SMIN && bus.src_b == '1) begin
        special     = 1'b1;
        special_val = (op_in == OP_DIV) ? bus.src_a : '0;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH-1:0] fast_ax;
  logic signed [2*WIDTH-1:0] fast_bx;
  logic signed [2*WIDTH-1:0] fast_prod;

  always_comb begin
    fast_ax   = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a};
    fast_bx   = {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
    fast_prod = fast_ax * fast_bx;
    fast_hit  = !is_div_in;
    fast_val  = (op_in == OP_MULH) ? fast_prod[2*WIDTH-1:WIDTH] : fast_prod[WIDTH-1:0];
  end
`else
  assign fast_hit = 1'b0;
  assign fast_val = '0;
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .dbit     (acc[WIDTH-1]),
    .divisor  (mag_d),
    .rem_next (d_rem),
    .qbit     (d_q)
  );

  // acc = {high, low}: multiply shifts right adding into high; divide shifts quotient bits into low.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_d} : '0);
    step_acc = (op_q == OP_DIV || op_q == OP_REM) ?
               {d_rem, acc[WIDTH-2:0], d_q} : {mul_sum, acc[WIDTH-1:1]};
    prod     = neg_q ? -step_acc : step_acc;
    fix_val  = '0;
    case (op_q)
      OP_MUL:  fix_val = prod[WIDTH-1:0];
      OP_MULH: fix_val = prod[2*WIDTH-1:WIDTH];
      OP_DIV:  fix_val = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      OP_REM:  fix_val = neg_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
      default: fix_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= '0;
      mag_d    <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_q  <= op_in;
            neg_q <= (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
            mag_d <= is_div_in ? mag_b : mag_a;
            acc   <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
            cnt   <= '0;
            if (special || fast_hit) begin
              result_q <= special ? special_val : fast_val;
              done_q   <= 1'b1;
              state    <= ST_FIN;
            end else begin
              busy_q <= 1'b1;
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            acc <= step_acc;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              result_q <= fix_val;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= ST_FIN;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = busy_q | (bus.start & (state == ST_IDLE));

endmodule
